// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants for the loader and the control decoder.
package riscv_pkg;

    // Symbolic instruction classes accepted by the loader
    typedef enum logic [2:0] {
        KIND_LW        = 3'd0,
        KIND_SW        = 3'd1,
        KIND_RTYPE     = 3'd2,
        KIND_BEQ       = 3'd3,
        KIND_ITYPE_ALU = 3'd4,
        KIND_JAL       = 3'd5
    } req_kind_e;

    // alu_control encoding shared with the ALU decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW_SW = 3'b010;
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    // Immediate scatter formats, matching the decoder's immsrc
    typedef enum logic [1:0] {
        IMMSRC_I = 2'b00,
        IMMSRC_S = 2'b01,
        IMMSRC_B = 2'b10,
        IMMSRC_J = 2'b11
    } immsrc_e;

    // funct3 for the ALU operations (add and sub share 000)
    function automatic logic [2:0] alu_funct3(input logic [2:0] alu);
        case (alu)
            ALU_AND: return 3'b111;
            ALU_OR:  return 3'b110;
            ALU_SLT: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // True for any alu_control value the ALU implements
    function automatic logic alu_known(input logic [2:0] alu);
        return (alu == ALU_ADD) || (alu == ALU_SUB) || (alu == ALU_AND) ||
               (alu == ALU_OR)  || (alu == ALU_SLT);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic request fields to an RV32I word plus legality flag.
module instr_encode
    import riscv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word_c,
    output logic        illegal_c
);

    logic signed [31:0] simm;
    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               is_rtype;
    immsrc_e            immsrc;

    assign simm = $signed(imm);

    // Select opcode/funct fields and check operand legality per class
    always_comb begin
        opcode    = '0;
        f3        = '0;
        f7        = '0;
        is_rtype  = 1'b0;
        immsrc    = IMMSRC_I;
        illegal_c = 1'b0;
        case (req_kind_e'(kind))
            KIND_LW: begin
                opcode    = OP_LOAD;
                f3        = F3_LW_SW;
                illegal_c = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            KIND_SW: begin
                opcode    = OP_STORE;
                f3        = F3_LW_SW;
                immsrc    = IMMSRC_S;
                illegal_c = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            KIND_RTYPE: begin
                opcode    = OP_RTYPE;
                f3        = alu_funct3(alu);
                f7        = (alu == ALU_SUB) ? F7_SUB : 7'b0;
                is_rtype  = 1'b1;
                illegal_c = !alu_known(alu);
            end
            KIND_ITYPE_ALU: begin
                opcode    = OP_ITYPE;
                f3        = alu_funct3(alu);
                illegal_c = !alu_known(alu) || (alu == ALU_SUB) ||
                            (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            KIND_BEQ: begin
                opcode    = OP_BRANCH;
                f3        = F3_BEQ;
                immsrc    = IMMSRC_B;
                illegal_c = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            KIND_JAL: begin
                opcode    = OP_JAL;
                immsrc    = IMMSRC_J;
                illegal_c = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Assemble the word; each format only carries the register fields it uses
    always_comb begin
        word_c = '0;
        if (is_rtype) begin
            word_c = {f7, rs2, rs1, f3, rd, opcode};
        end else begin
            case (immsrc)
                IMMSRC_I: word_c = {imm[11:0], rs1, f3, rd, opcode};
                IMMSRC_S: word_c = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
                IMMSRC_B: word_c = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
                IMMSRC_J: word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                default:  word_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes symbolic requests and writes them sequentially into instruction memory.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [2:0]                     req_kind,
    input  logic [2:0]                     req_alu,
    input  logic [4:0]                     req_rd,
    input  logic [4:0]                     req_rs1,
    input  logic [4:0]                     req_rs2,
    input  logic [31:0]                    req_imm,
    input  logic                           finish,
    input  logic                           clear,
    output logic                           imem_we,
    output logic [31:0]                    imem_addr,
    output logic [31:0]                    imem_wdata,
    output logic                           cpu_hold,
    output logic                           err,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic [31:0]        enc_word;
    logic               enc_illegal;
    logic               accept;

    instr_encode u_encode (
        .kind      (req_kind),
        .alu       (req_alu),
        .rd        (req_rd),
        .rs1       (req_rs1),
        .rs2       (req_rs2),
        .imm       (req_imm),
        .word_c    (enc_word),
        .illegal_c (enc_illegal)
    );

    // Handshake: clear blocks acceptance in the same cycle
    assign req_ready = (state_q == ST_LOAD) && !clear && (count_q < CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready;

    // Next-state, write-port and counter logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            if (enc_illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + (32'(count_q) << 2);
                wdata_d = enc_word;
                count_d = count_q + CNT_W'(1);
            end
        end
        case (state_q)
            ST_LOAD: begin
                if (clear) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (finish || (we_d && (count_d == CNT_W'(DEPTH)))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        hold_d = (state_d == ST_LOAD) || we_d;
    end

    // State and output registers; reset drops any in-flight write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign err        = err_q;
    assign count      = count_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: vector table, corner sequences, random run.
module tb_instr_encoder_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [2:0]  req_alu;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        finish;
    logic        clear;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        err;
    logic [2:0]  count;
    logic        done;

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_alu    (req_alu),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .finish     (finish),
        .clear      (clear),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .err        (err),
        .count      (count),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_load;
    int          m_count;
    bit          m_err;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    typedef struct {
        int          kind;
        int          alu;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
        bit          bad;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Legality from the stated operand rules
    function automatic bit m_legal(input int kind, input int alu, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (kind)
            0, 1:    return (v >= -2048) && (v <= 2047);
            2:       return alu == 0 || alu == 1 || alu == 2 || alu == 3 || alu == 5;
            4:       return (alu == 0 || alu == 2 || alu == 3 || alu == 5) && (v >= -2048) && (v <= 2047);
            3:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            5:       return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_f3(input int alu);
        case (alu)
            2:       return 32'd7;
            3:       return 32'd6;
            5:       return 32'd2;
            default: return 32'd0;
        endcase
    endfunction

    // Encoding built from field positions with shifts and masks
    function automatic logic [31:0] m_encode(input int kind, input int alu, input int rd,
                                             input int rs1, input int rs2, input logic [31:0] imm);
        logic [31:0] d, s1, s2;
        d  = 32'(rd)  << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        case (kind)
            0: return ((imm & 32'hFFF) << 20) | s1 | (32'd2 << 12) | d | 32'h03;
            1: return (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | (32'd2 << 12) |
                      ((imm & 32'h1F) << 7) | 32'h23;
            2: return ((alu == 1) ? 32'h4000_0000 : 32'h0) | s2 | s1 | (m_f3(alu) << 12) | d | 32'h33;
            4: return ((imm & 32'hFFF) << 20) | s1 | (m_f3(alu) << 12) | d | 32'h13;
            3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 |
                      (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive, check ready, advance model, check registered outputs
    task automatic cyc(input bit v, input int kind, input int alu, input int rd, input int rs1,
                       input int rs2, input logic [31:0] imm, input bit fin, input bit clr, input bit rst);
        bit          exp_ready, acc, lg;
        logic [31:0] w;
        req_valid = v;
        req_kind  = 3'(kind);
        req_alu   = 3'(alu);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
        finish    = fin;
        clear     = clr;
        reset     = rst;
        #1;
        exp_ready = m_load && !clr && (m_count < DEPTH);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        acc = v && exp_ready;
        lg  = m_legal(kind, alu, imm);
        w   = m_encode(kind, alu, rd, rs1, rs2, imm);
        @(posedge clk);
        #1;
        if (rst) begin
            m_load = 1'b1; m_count = 0; m_err = 1'b0; m_we = 1'b0;
            m_addr = BASE; m_wdata = 32'h0;
        end else begin
            m_we = acc && lg;
            if (m_we) begin
                m_addr  = BASE + 32'(4 * m_count);
                m_wdata = w;
                m_count++;
            end
            if (acc && !lg) m_err = 1'b1;
            if (clr) begin
                m_count = 0; m_err = 1'b0; m_load = 1'b1;
            end else if (m_load && (fin || (m_we && m_count == DEPTH))) begin
                m_load = 1'b0;
            end
        end
        chk("imem_we",    32'(imem_we),  32'(m_we));
        chk("imem_addr",  imem_addr,     m_addr);
        chk("imem_wdata", imem_wdata,    m_wdata);
        chk("count",      32'(count),    32'(m_count));
        chk("err",        32'(err),      32'(m_err));
        chk("done",       32'(done),     32'(!m_load));
        chk("cpu_hold",   32'(cpu_hold), 32'(m_load || m_we));
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cyc(1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] pick_imm();
        int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                        -1048576, -1048578, 1048574, 1048575, 1048576};
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 32)) - 32'd16;
            1:       return $urandom;
            2:       return 32'(bnd[$urandom_range(0, 13)]);
            3:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            4:       return (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        int          pre_cnt;
        bit          hold_req;
        int          rk, ra, rd, r1, r2;
        logic [31:0] ri;
        bit          rv;

        tbl[0]  = '{2, 0, 3, 1, 2, 32'h0000_0000, 1'b0, 32'h002081B3};
        tbl[1]  = '{2, 1, 3, 1, 2, 32'h0000_0000, 1'b0, 32'h402081B3};
        tbl[2]  = '{0, 7, 5, 1, 7, 32'h0000_0008, 1'b0, 32'h0080A283};
        tbl[3]  = '{1, 7, 9, 1, 5, 32'h0000_0008, 1'b0, 32'h0050A423};
        tbl[4]  = '{3, 7, 9, 1, 2, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3};
        tbl[5]  = '{4, 1, 3, 1, 2, 32'h0000_0008, 1'b1, 32'h0};
        tbl[6]  = '{3, 0, 0, 1, 2, 32'h0000_0003, 1'b1, 32'h0};
        tbl[7]  = '{0, 0, 5, 1, 0, 32'h0000_0800, 1'b1, 32'h0};
        tbl[8]  = '{6, 0, 1, 1, 1, 32'h0000_0000, 1'b1, 32'h0};
        tbl[9]  = '{2, 4, 1, 1, 1, 32'h0000_0000, 1'b1, 32'h0};
        tbl[10] = '{5, 0, 1, 3, 4, 32'h0000_0800, 1'b0, 32'h001000EF};
        tbl[11] = '{5, 0, 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 32'hFFFFF06F};
        tbl[12] = '{4, 5, 2, 3, 0, 32'hFFFF_FFFF, 1'b0, 32'hFFF1A113};
        tbl[13] = '{3, 0, 0, 0, 0, 32'h0000_0FFE, 1'b0, 32'h7E000FE3};
        tbl[14] = '{3, 0, 0, 0, 0, 32'h0000_1000, 1'b1, 32'h0};
        tbl[15] = '{5, 0, 0, 0, 0, 32'h0010_0000, 1'b1, 32'h0};
        tbl[16] = '{4, 2, 1, 1, 0, 32'h0000_07FF, 1'b0, 32'h7FF0F093};
        tbl[17] = '{0, 0, 0, 0, 0, 32'hFFFF_F800, 1'b0, 32'h80002003};
        tbl[18] = '{5, 0, 0, 0, 0, 32'hFFF0_0000, 1'b0, 32'h8000006F};
        tbl[19] = '{4, 3, 4, 5, 0, 32'hFFFF_F800, 1'b0, 32'h8002E213};

        // Reset state
        reset = 1'b1; req_valid = 1'b0; req_kind = '0; req_alu = '0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; finish = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    32'(imem_we),  32'd0);
        chk("rst_addr",  imem_addr,     BASE);
        chk("rst_wdata", imem_wdata,    32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_count", 32'(count),    32'd0);
        chk("rst_err",   32'(err),      32'd0);
        chk("rst_done",  32'(done),     32'd0);
        m_load = 1'b1; m_count = 0; m_err = 1'b0; m_we = 1'b0; m_addr = BASE; m_wdata = 32'h0;
        idle();

        // Encoding table
        foreach (tbl[i]) begin
            if (!m_load || m_count == DEPTH) do_clear();
            pre_cnt = m_count;
            cyc(1'b1, tbl[i].kind, tbl[i].alu, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_we", i), 32'(imem_we), 32'(!tbl[i].bad));
            if (!tbl[i].bad) begin
                chk($sformatf("tbl%0d_word", i), imem_wdata, tbl[i].word);
                chk($sformatf("tbl%0d_addr", i), imem_addr, BASE + 32'(4 * pre_cnt));
            end else begin
                chk($sformatf("tbl%0d_err", i), 32'(err), 32'd1);
                chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(pre_cnt));
            end
        end

        // Back-to-back writes
        do_clear();
        cyc(1'b1, 2, 1, 3, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("b2b_we0",   32'(imem_we), 32'd1);
        chk("b2b_addr0", imem_addr,    BASE);
        chk("b2b_data0", imem_wdata,   32'h402081B3);
        cyc(1'b1, 0, 0, 5, 1, 0, 32'h8, 1'b0, 1'b0, 1'b0);
        chk("b2b_we1",   32'(imem_we), 32'd1);
        chk("b2b_addr1", imem_addr,    BASE + 32'd4);
        chk("b2b_data1", imem_wdata,   32'h0080A283);

        // Fill to DEPTH, hold release, then clear and restart
        do_clear();
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, 2, 0, k + 1, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_done",  32'(done),      32'd1);
        chk("fill_ready", 32'(req_ready), 32'd0);
        chk("fill_hold",  32'(cpu_hold),  32'd1);
        chk("fill_addr",  imem_addr,      BASE + 32'd12);
        idle();
        chk("fill_hold_off", 32'(cpu_hold), 32'd0);
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_done",  32'(done),  32'd0);
        cyc(1'b1, 2, 0, 3, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("clr_addr", imem_addr, BASE);

        // Write in flight across a clear, then clear with a request present
        cyc(1'b1, 2, 0, 3, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 0, 3, 1, 2, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("clrv_we",    32'(imem_we), 32'd0);
        chk("clrv_count", 32'(count),   32'd0);

        // finish together with an accept
        cyc(1'b1, 0, 0, 5, 1, 0, 32'h8, 1'b1, 1'b0, 1'b0);
        chk("fin_we",   32'(imem_we), 32'd1);
        chk("fin_done", 32'(done),    32'd1);
        chk("fin_hold", 32'(cpu_hold), 32'd1);
        idle();

        // Reset one cycle after an accept, and reset together with an accept
        do_clear();
        cyc(1'b1, 2, 0, 3, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rsta_we",    32'(imem_we),  32'd0);
        chk("rsta_hold",  32'(cpu_hold), 32'd1);
        chk("rsta_count", 32'(count),    32'd0);
        cyc(1'b1, 2, 0, 3, 1, 2, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rstb_we", 32'(imem_we), 32'd0);
        idle();
        chk("rstb_idle_we", 32'(imem_we), 32'd0);

        // Randomized run against the model
        hold_req = 1'b0;
        rk = 0; ra = 0; rd = 0; r1 = 0; r2 = 0; ri = 32'h0; rv = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold_req) begin
                rv = ($urandom_range(0, 9) < 7);
                rk = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                ra = $urandom_range(0, 7);
                rd = $urandom_range(0, 31);
                r1 = $urandom_range(0, 31);
                r2 = $urandom_range(0, 31);
                ri = pick_imm();
            end
            begin
                bit f, c, r;
                f = ($urandom_range(0, 99) < 3);
                c = ($urandom_range(0, 99) < 5);
                r = ($urandom_range(0, 99) < 1);
                hold_req = rv && !(m_load && !c && (m_count < DEPTH));
                cyc(rv, rk, ra, rd, r1, r2, ri, f, c, r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
